memory_requester: RTL and testbench
===================================

# memory_requester

Initiator-side endpoint of the word-addressed memory channel protocol, one per CPU memory client (instruction fetch, load/store). It accepts RISC-V style load/store requests of byte, halfword or word width. It converts each request into word-aligned channel transactions to the memory controller, including read-modify-write for sub-word stores. It returns sign- or zero-extended load data, or an error, to the CPU pipeline.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: word width. Fixed at 32; other values are unsupported.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock` in 1: sole clock, rising edge.
- `clear_n` in 1: asynchronous active-low reset.
- CPU request side:
  - `req_valid` in 1: request present.
  - `req_ready` out 1: block can accept a request.
  - `req_write` in 1: 1 = store, 0 = load.
  - `req_funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores use only 000/001/010.
  - `req_address` in ADDR_W: byte address.
  - `req_write_data` in DATA_W: store data, right-justified.
- CPU response side:
  - `rsp_valid` out 1: one-cycle response pulse.
  - `rsp_error` out 1: request failed.
  - `rsp_data` out DATA_W: extended load data; 0 for stores.
- Memory channel request side:
  - `mem_valid` out 1: channel request present.
  - `mem_ready` in 1: controller accepts the request this cycle.
  - `mem_write` out 1: channel write.
  - `mem_address` out ADDR_W: byte address with [1:0] forced to 00.
  - `mem_write_data` out DATA_W: full word to write.
- Memory channel response side:
  - `mem_rsp_valid` in 1: controller response pulse.
  - `mem_rsp_error` in 1: controller flagged the access illegal.
  - `mem_rsp_read_data` in DATA_W: word read.
  - `mem_rsp_ready` out 1: requester can take a response.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture the address, funct3, write flag and data.
  - If misaligned (H/HU with addr[0]=1, or W with addr[1:0]!=00), or funct3 is illegal for the direction, go to RESP with error.
  - Otherwise: load or sub-word store goes to RD_REQ; word store goes to WR_REQ.
- RD_REQ / WR_REQ:
  - `mem_valid`=1 and all `mem_*` fields held stable until `mem_ready`.
  - On handshake, go to RD_WAIT / WR_WAIT.
- RD_WAIT / WR_WAIT:
  - `mem_rsp_ready`=1. Wait indefinitely for `mem_rsp_valid`.
  - If `mem_rsp_error`=1, go to RESP with error.
  - RD_WAIT on a load: extract lane `addr[1:0]`, sign- or zero-extend, go to RESP.
  - RD_WAIT on a sub-word store: merge the byte/halfword into the read word in a register, go to WR_REQ.
  - WR_WAIT: go to RESP.
- RESP: drive `rsp_valid`=1 for exactly one cycle, then return to IDLE.
- `mem_rsp_valid` in IDLE, RD_REQ, WR_REQ or RESP is ignored. This covers stale responses after reset.
- Byte lanes are little-endian: lane k = bits [8k+7:8k].

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_error`=0, `rsp_data`=0, `mem_valid`=0, `mem_write`=0, `mem_address`=0, `mem_write_data`=0, `mem_rsp_ready`=0. FSM state = IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from `mem_*` inputs to `req_*`/`rsp_*` outputs.
- Minimum latencies, with request accepted at cycle t and `mem_ready` immediate:
  - Load: `rsp_valid` at t+3.
  - Word store: `rsp_valid` at t+3.
  - Sub-word store: `rsp_valid` at t+5.
  - Local error: `rsp_valid` at t+1.
- Each extra cycle `mem_ready` is low adds one cycle.
- One transaction is outstanding at a time. A new request is accepted no earlier than the cycle after the `rsp_valid` pulse.
- Reset asserted mid-transaction aborts it immediately. No response is produced.

## Configuration
- `MEMORY_REQUESTER_SUBWORD_STORE_EN`:
  - Defined: SB/SH run the read-modify-write sequence above.
  - Undefined: SB/SH are rejected in IDLE with `rsp_error`=1 at t+1, and no channel traffic occurs. Loads of every width are unaffected.

## Structure
- Shared package `memory_channel_pkg`:
  - funct3 width constants (`FUNCT3_B`, `FUNCT3_H`, `FUNCT3_W`, `FUNCT3_BU`, `FUNCT3_HU`).
  - State enum `requester_state_t`.
  - Request/response struct typedefs, reused by the controller side.
- One sub-module, `memory_lane_unit`: combinational lane extract plus sign/zero extension for loads, and lane merge for stores. This keeps the FSM file free of datapath muxing.

## Test plan
- LW at 0x0000_0010: controller returns 0xDEAD_BEEF -> `mem_address`=0x10, `rsp_data`=0xDEAD_BEEF, `rsp_error`=0, `rsp_valid` at t+3.
- LB at 0x13, then LBU at 0x13, with word 0x80FF_0102 -> `rsp_data`=0xFFFF_FF80, then 0x0000_0080.
- SB 0xAB at 0x21 with old word 0x1122_3344 (macro defined) -> `mem_address`=0x20, read then write 0x1122_AB44, `rsp_valid` at t+5. Same stimulus with macro undefined -> `rsp_error`=1 at t+1, `mem_valid` never asserted.
- LW at 0x0000_0006 -> `rsp_error`=1 at t+1, no `mem_valid`. LH at 0x03 -> same result.
- `mem_ready` held low 7 cycles on SW 0x5555_AAAA to 0x40 -> `mem_valid`/`mem_address`/`mem_write_data` stable throughout; `rsp_valid` at t+10.
- `mem_rsp_error`=1 on LW at 0x4000 -> `rsp_error`=1, `rsp_data`=0. Also: `clear_n` pulsed low in RD_WAIT -> all outputs at reset values, and the late `mem_rsp_valid` produces no `rsp_valid`.

Source files
------------

// File: rtl/memory_channel_pkg.sv
// Shared types for the word-addressed memory channel: funct3 codes, requester FSM states,
// channel request/response records and request legality helpers.
package memory_channel_pkg;

   localparam logic [2:0] FUNCT3_B  = 3'b000;
   localparam logic [2:0] FUNCT3_H  = 3'b001;
   localparam logic [2:0] FUNCT3_W  = 3'b010;
   localparam logic [2:0] FUNCT3_BU = 3'b100;
   localparam logic [2:0] FUNCT3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_WAIT,
      RESP
   } requester_state_t;

   typedef struct packed {
      logic        write;
      logic [2:0]  funct3;
   } req_kind_t;

   typedef struct packed {
      logic        write;
      logic [31:0] address;
      logic [31:0] write_data;
   } mem_req_t;

   typedef struct packed {
      logic        error;
      logic [31:0] read_data;
   } mem_rsp_t;

   // Stores only come in B/H/W, and B/H stores exist only when read-modify-write is built in.
   function automatic logic funct3_legal(input logic write, input logic [2:0] funct3,
                                         input logic subword_en);
      if (write)
         return (funct3 == FUNCT3_W) ||
                (subword_en && ((funct3 == FUNCT3_B) || (funct3 == FUNCT3_H)));
      return (funct3 == FUNCT3_B) || (funct3 == FUNCT3_H) || (funct3 == FUNCT3_W) ||
             (funct3 == FUNCT3_BU) || (funct3 == FUNCT3_HU);
   endfunction

   function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3)
         FUNCT3_H, FUNCT3_HU: return offset[0];
         FUNCT3_W:            return offset != 2'b00;
         default:             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/memory_lane_unit.sv
// Byte-lane datapath for the requester: little-endian lane extract with sign/zero extension
// for loads, and byte/halfword merge into a read word for sub-word stores.
module memory_lane_unit
   import memory_channel_pkg::*;
(
   input  logic [31:0] read_word,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane = read_word[{offset, 3'b000} +: 8];
      half_lane = offset[1] ? read_word[31:16] : read_word[15:0];
      case (funct3)
         FUNCT3_B:  load_data = {{24{byte_lane[7]}}, byte_lane};
         FUNCT3_BU: load_data = {24'h0, byte_lane};
         FUNCT3_H:  load_data = {{16{half_lane[15]}}, half_lane};
         FUNCT3_HU: load_data = {16'h0, half_lane};
         default:   load_data = read_word;
      endcase
   end

   // Only the addressed lanes are replaced; the rest of the old word is written back unchanged.
   always_comb begin
      merged_word = read_word;
      case (funct3)
         FUNCT3_B: merged_word[{offset, 3'b000} +: 8] = store_data[7:0];
         FUNCT3_H: begin
            if (offset[1])
               merged_word[31:16] = store_data[15:0];
            else
               merged_word[15:0] = store_data[15:0];
         end
         default:  merged_word = store_data;
      endcase
   end

endmodule

// File: rtl/memory_requester.sv
// CPU-side initiator for the memory channel: one request at a time, word-aligned channel traffic.
// Define MEMORY_REQUESTER_SUBWORD_STORE_EN to build SB/SH as read-modify-write; otherwise they error.
module memory_requester
   import memory_channel_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_address,
   input  logic [DATA_W-1:0] req_write_data,
   output logic              rsp_valid,
   output logic              rsp_error,
   output logic [DATA_W-1:0] rsp_data,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_rsp_valid,
   input  logic              mem_rsp_error,
   input  logic [DATA_W-1:0] mem_rsp_read_data,
   output logic              mem_rsp_ready
);

`ifdef MEMORY_REQUESTER_SUBWORD_STORE_EN
   localparam logic SUBWORD_EN = 1'b1;
`else
   localparam logic SUBWORD_EN = 1'b0;
`endif

   requester_state_t  state, next_state;
   logic [ADDR_W-1:0] addr_q;
   req_kind_t         kind_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic              rsp_error_q;
   logic [DATA_W-1:0] load_data;
   logic [DATA_W-1:0] merged_word;
   logic              req_ok;
   mem_rsp_t          mem_rsp;

   assign mem_rsp = {mem_rsp_error, mem_rsp_read_data};
   assign req_ok  = funct3_legal(req_write, req_funct3, SUBWORD_EN) &&
                    !misaligned(req_funct3, req_address[1:0]);

   memory_lane_unit u_lane (
      .read_word   (mem_rsp.read_data),
      .funct3      (kind_q.funct3),
      .offset      (addr_q[1:0]),
      .store_data  (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (!req_ok)
                  next_state = RESP;
               else if (req_write && (req_funct3 == FUNCT3_W))
                  next_state = WR_REQ;
               else
                  next_state = RD_REQ;
            end
         end
         RD_REQ:  if (mem_ready) next_state = RD_WAIT;
         RD_WAIT: begin
            if (mem_rsp_valid)
               next_state = (!mem_rsp.error && kind_q.write) ? WR_REQ : RESP;
         end
         WR_REQ:  if (mem_ready) next_state = WR_WAIT;
         WR_WAIT: if (mem_rsp_valid) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Handshake outputs are pure state decodes, so no mem_* input reaches the CPU side combinationally.
   always_comb begin
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      mem_valid     = 1'b0;
      mem_write     = 1'b0;
      mem_rsp_ready = 1'b0;
      case (state)
         IDLE:    req_ready = 1'b1;
         RD_REQ:  mem_valid = 1'b1;
         WR_REQ: begin
            mem_valid = 1'b1;
            mem_write = 1'b1;
         end
         RD_WAIT, WR_WAIT: mem_rsp_ready = 1'b1;
         RESP:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_write_data = wdata_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_error      = rsp_error_q;

   // wdata_q holds the raw store data until a sub-word read returns, then the merged word to write.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         addr_q      <= '0;
         kind_q      <= '0;
         wdata_q     <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q      <= req_address;
                  kind_q      <= {req_write, req_funct3};
                  wdata_q     <= req_write_data;
                  rsp_data_q  <= '0;
                  rsp_error_q <= !req_ok;
               end
            end
            RD_WAIT: begin
               if (mem_rsp_valid) begin
                  if (mem_rsp.error) begin
                     rsp_error_q <= 1'b1;
                     rsp_data_q  <= '0;
                  end else if (kind_q.write) begin
                     wdata_q <= merged_word;
                  end else begin
                     rsp_data_q <= load_data;
                  end
               end
            end
            WR_WAIT: begin
               if (mem_rsp_valid)
                  rsp_error_q <= mem_rsp.error;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_requester.sv
// Self-checking bench for memory_requester: directed vector table, reset-abort sequence and
// randomized transactions against a word-level reference model of the load/store rules.
module tb_memory_requester;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BUDGET = 40;
`ifdef MEMORY_REQUESTER_SUBWORD_STORE_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic              clock = 1'b0;
   logic              clear_n = 1'b0;
   logic              req_valid, req_ready, req_write;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_address;
   logic [DATA_W-1:0] req_write_data;
   logic              rsp_valid, rsp_error;
   logic [DATA_W-1:0] rsp_data;
   logic              mem_valid, mem_ready, mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_rsp_valid, mem_rsp_error, mem_rsp_ready;
   logic [DATA_W-1:0] mem_rsp_read_data;

   always #5 clock = ~clock;

   memory_requester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock             (clock),
      .clear_n           (clear_n),
      .req_valid         (req_valid),
      .req_ready         (req_ready),
      .req_write         (req_write),
      .req_funct3        (req_funct3),
      .req_address       (req_address),
      .req_write_data    (req_write_data),
      .rsp_valid         (rsp_valid),
      .rsp_error         (rsp_error),
      .rsp_data          (rsp_data),
      .mem_valid         (mem_valid),
      .mem_ready         (mem_ready),
      .mem_write         (mem_write),
      .mem_address       (mem_address),
      .mem_write_data    (mem_write_data),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_error     (mem_rsp_error),
      .mem_rsp_read_data (mem_rsp_read_data),
      .mem_rsp_ready     (mem_rsp_ready)
   );

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [31:0] ctrl_mem [0:255];
   logic [31:0] ref_mem  [0:255];

   int          stall_cfg     = 0;
   int          rsp_delay_cfg = 0;
   bit          merr_cfg      = 1'b0;
   int          stall_seen    = 0;
   int          pend_cnt      = 0;
   int          grant_count   = 0;
   bit          unstable      = 1'b0;
   bit          pend_write;
   logic [31:0] pend_addr, pend_data, last_addr;
   logic [64:0] snap;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Memory controller model: stalls mem_ready, answers one cycle after each grant (plus delay).
   initial begin
      mem_ready         = 1'b0;
      mem_rsp_valid     = 1'b0;
      mem_rsp_error     = 1'b0;
      mem_rsp_read_data = '0;
      last_addr         = '0;
      forever begin
         @(negedge clock);
         mem_rsp_valid = 1'b0;
         mem_rsp_error = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mem_rsp_valid     = 1'b1;
               mem_rsp_error     = merr_cfg;
               mem_rsp_read_data = merr_cfg ? 32'h0BAD_0BAD : ctrl_mem[pend_addr[9:2]];
               if (pend_write && !merr_cfg)
                  ctrl_mem[pend_addr[9:2]] = pend_data;
            end
         end
         mem_ready = 1'b0;
         if (mem_valid) begin
            if (stall_seen == 0)
               snap = {mem_write, mem_address, mem_write_data};
            else if (snap !== {mem_write, mem_address, mem_write_data})
               unstable = 1'b1;
            if (stall_seen >= stall_cfg) begin
               mem_ready  = 1'b1;
               stall_seen = 0;
               grant_count++;
               last_addr  = mem_address;
               pend_write = mem_write;
               pend_addr  = mem_address;
               pend_data  = mem_write_data;
               pend_cnt   = rsp_delay_cfg + 1;
            end else begin
               stall_seen++;
            end
         end else begin
            stall_seen = 0;
         end
      end
   end

   // Issues one request and measures cycles from acceptance to the rsp_valid pulse (-1 = timeout).
   task automatic applyStimulus(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output int lat, output logic err,
                                output logic [31:0] data);
      @(negedge clock);
      checkOutput("idle_req_ready", req_ready, 32'd1);
      checkOutput("rsp_pulse_ended", rsp_valid, 32'd0);
      req_valid      = 1'b1;
      req_write      = w;
      req_funct3     = f3;
      req_address    = a;
      req_write_data = wd;
      grant_count    = 0;
      lat            = -1;
      err            = 1'bx;
      data           = 'x;
      @(negedge clock);
      req_valid = 1'b0;
      for (int k = 1; k <= BUDGET; k++) begin
         if (rsp_valid === 1'b1) begin
            lat  = k;
            err  = rsp_error;
            data = rsp_data;
            break;
         end
         @(negedge clock);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_req_ready"},      req_ready,      32'd1);
      checkOutput({tag, "_rsp_valid"},      rsp_valid,      32'd0);
      checkOutput({tag, "_rsp_error"},      rsp_error,      32'd0);
      checkOutput({tag, "_rsp_data"},       rsp_data,       32'd0);
      checkOutput({tag, "_mem_valid"},      mem_valid,      32'd0);
      checkOutput({tag, "_mem_write"},      mem_write,      32'd0);
      checkOutput({tag, "_mem_address"},    mem_address,    32'd0);
      checkOutput({tag, "_mem_write_data"}, mem_write_data, 32'd0);
      checkOutput({tag, "_mem_rsp_ready"},  mem_rsp_ready,  32'd0);
   endtask

   // Reference model: RISC-V load/store semantics on whole words with plain arithmetic.
   task automatic model_txn(input bit w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int stall, input bit merr,
                            output bit e, output logic [31:0] d, output int lat);
      int          size, off;
      bit          legal;
      logic [63:0] word, v, mask;
      case (f3[1:0])
         2'd0:    size = 1;
         2'd1:    size = 2;
         2'd2:    size = 4;
         default: size = 0;
      endcase
      if (w) legal = (f3 == 3'd2) || (SUBWORD && (f3 == 3'd0 || f3 == 3'd1));
      else   legal = (size != 0) && (f3 != 3'd6);
      off = int'(a % 4);
      e   = 1'b0;
      d   = '0;
      lat = 1;
      if (!legal || (off % size) != 0) begin
         e = 1'b1;
         return;
      end
      word = {32'h0, ref_mem[a[9:2]]};
      if (!w) begin
         lat = 3 + stall;
         if (merr) begin
            e = 1'b1;
            return;
         end
         v = (word >> (8 * off)) % (64'd1 << (8 * size));
         if (!f3[2] && v >= (64'd1 << (8 * size - 1)))
            v = v - (64'd1 << (8 * size));
         d = v[31:0];
      end else if (size == 4) begin
         lat = 3 + stall;
         e   = merr;
         if (!merr) ref_mem[a[9:2]] = wd;
      end else if (merr) begin
         lat = 3 + stall;
         e   = 1'b1;
      end else begin
         lat  = 5 + 2 * stall;
         mask = ((64'd1 << (8 * size)) - 1) << (8 * off);
         v    = (word & ~mask) | (({32'h0, wd} << (8 * off)) & mask);
         ref_mem[a[9:2]] = v[31:0];
      end
   endtask

   typedef struct {
      bit          write;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] init_word;
      int          stall;
      bit          merr;
      bit          exp_err;
      logic [31:0] exp_data;
      int          exp_lat;
      logic [31:0] exp_word;
      int          exp_reqs;
      logic [31:0] exp_addr;
   } vec_t;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs[15];
      int          lat, exp_lat;
      logic        err;
      bit          exp_e, w, merr, saw;
      logic [31:0] data, exp_d, a, wd;
      logic [2:0]  f3;
      int          stall;

      req_valid = 1'b0;
      req_write = 1'b0;
      req_funct3 = '0;
      req_address = '0;
      req_write_data = '0;
      for (int i = 0; i < 256; i++) ctrl_mem[i] = $urandom;

      vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 1'b0,
                   1'b0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF, 1, 32'h10};
      vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0, 32'h80FF_0102, 0, 1'b0,
                   1'b0, 32'hFFFF_FF80, 3, 32'h80FF_0102, 1, 32'h10};
      vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h80FF_0102, 0, 1'b0,
                   1'b0, 32'h0000_0080, 3, 32'h80FF_0102, 1, 32'h10};
`ifdef MEMORY_REQUESTER_SUBWORD_STORE_EN
      vecs[3]  = '{1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h1122_3344, 0, 1'b0,
                   1'b0, 32'h0, 5, 32'h1122_AB44, 2, 32'h20};
      vecs[12] = '{1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h1122_3344, 0, 1'b0,
                   1'b0, 32'h0, 5, 32'hBEEF_3344, 2, 32'h20};
`else
      vecs[3]  = '{1'b1, 3'b000, 32'h21, 32'h0000_00AB, 32'h1122_3344, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h1122_3344, 0, 32'h0};
      vecs[12] = '{1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h1122_3344, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h1122_3344, 0, 32'h0};
`endif
      vecs[4]  = '{1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h0, 0, 32'h0};
      vecs[5]  = '{1'b0, 3'b001, 32'h03, 32'h0, 32'h0, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h0, 0, 32'h0};
      vecs[6]  = '{1'b1, 3'b010, 32'h40, 32'h5555_AAAA, 32'h0, 7, 1'b0,
                   1'b0, 32'h0, 10, 32'h5555_AAAA, 1, 32'h40};
      vecs[7]  = '{1'b0, 3'b010, 32'h4000, 32'h0, 32'hCAFE_F00D, 0, 1'b1,
                   1'b1, 32'h0, 3, 32'hCAFE_F00D, 1, 32'h4000};
      vecs[8]  = '{1'b0, 3'b101, 32'h12, 32'h0, 32'h80FF_0102, 0, 1'b0,
                   1'b0, 32'h0000_80FF, 3, 32'h80FF_0102, 1, 32'h10};
      vecs[9]  = '{1'b0, 3'b001, 32'h12, 32'h0, 32'h80FF_0102, 0, 1'b0,
                   1'b0, 32'hFFFF_80FF, 3, 32'h80FF_0102, 1, 32'h10};
      vecs[10] = '{1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h0, 0, 32'h0};
      vecs[11] = '{1'b1, 3'b100, 32'h08, 32'h1234, 32'h0, 0, 1'b0,
                   1'b1, 32'h0, 1, 32'h0, 0, 32'h0};
      vecs[13] = '{1'b1, 3'b010, 32'h30, 32'h1234_5678, 32'h0A0A_0A0A, 0, 1'b1,
                   1'b1, 32'h0, 3, 32'h0A0A_0A0A, 1, 32'h30};
      vecs[14] = '{1'b0, 3'b000, 32'h11, 32'h0, 32'h80FF_0102, 2, 1'b0,
                   1'b0, 32'h0000_0001, 5, 32'h80FF_0102, 1, 32'h10};

      clear_n = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_values("reset");
      clear_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         ctrl_mem[vecs[i].addr[9:2]] = vecs[i].init_word;
         stall_cfg = vecs[i].stall;
         merr_cfg  = vecs[i].merr;
         unstable  = 1'b0;
         applyStimulus(vecs[i].write, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, data);
         checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         checkOutput($sformatf("v%0d_rsp_error", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
         checkOutput($sformatf("v%0d_rsp_data", i), data, vecs[i].exp_data);
         checkOutput($sformatf("v%0d_mem_word", i), ctrl_mem[vecs[i].addr[9:2]], vecs[i].exp_word);
         checkOutput($sformatf("v%0d_mem_requests", i), 32'(grant_count), 32'(vecs[i].exp_reqs));
         checkOutput($sformatf("v%0d_stable", i), {31'h0, unstable}, 32'd0);
         if (vecs[i].exp_reqs > 0)
            checkOutput($sformatf("v%0d_mem_address", i), last_addr, vecs[i].exp_addr);
      end
      stall_cfg = 0;
      merr_cfg  = 1'b0;

      // Reset while waiting for read data; the late response must not produce rsp_valid.
      rsp_delay_cfg = 3;
      ctrl_mem[4]   = 32'h1234_5678;
      @(negedge clock);
      req_valid   = 1'b1;
      req_write   = 1'b0;
      req_funct3  = 3'b010;
      req_address = 32'h10;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      checkOutput("rd_wait_rsp_ready", mem_rsp_ready, 32'd1);
      clear_n = 1'b0;
      #1;
      check_reset_values("abort");
      @(negedge clock);
      clear_n = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clock);
         if (rsp_valid === 1'b1) saw = 1'b1;
      end
      checkOutput("stale_rsp_ignored", {31'h0, saw}, 32'd0);
      rsp_delay_cfg = 0;
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, lat, err, data);
      checkOutput("recover_latency", 32'(lat), 32'd3);
      checkOutput("recover_rsp_data", data, 32'h1234_5678);

      for (int i = 0; i < 256; i++) ref_mem[i] = ctrl_mem[i];
      for (int n = 0; n < 150; n++) begin
         w     = 1'($urandom_range(0, 1));
         f3    = 3'($urandom_range(0, 7));
         a     = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         wd    = $urandom;
         stall = int'($urandom_range(0, 2));
         merr  = ($urandom_range(0, 7) == 0);
         model_txn(w, f3, a, wd, stall, merr, exp_e, exp_d, exp_lat);
         stall_cfg = stall;
         merr_cfg  = merr;
         applyStimulus(w, f3, a, wd, lat, err, data);
         checkOutput($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat));
         checkOutput($sformatf("rand%0d_rsp_error", n), {31'h0, err}, {31'h0, exp_e});
         checkOutput($sformatf("rand%0d_rsp_data", n), data, exp_d);
         if (w)
            checkOutput($sformatf("rand%0d_mem_word", n), ctrl_mem[a[9:2]], ref_mem[a[9:2]]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
